// File: rtl/field_builder.sv
// field_builder: multi-cycle rasteriser of snake segments and apple into a 2-bit-per-cell field map.
// Define FIELD_BUILDER_WALLS_EN to have every build start from a field with blocked border cells.
module field_builder #(
    parameter int SIZE_X  = 10,
    parameter int SIZE_Y  = 10,
    parameter int COORD_W = 8,
    parameter int MAX_LEN = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic [15:0]                  lengh,
    input  logic [2*COORD_W*MAX_LEN-1:0] snake_xy,
    input  logic [COORD_W-1:0]           apple_x,
    input  logic [COORD_W-1:0]           apple_y,
    input  logic                         apple_valid,
    output logic [2*SIZE_X*SIZE_Y-1:0]   field,
    output logic [15:0]                  empty_cells,
    output logic                         busy,
    output logic                         done,
    output logic                         collision,
    output logic                         oob,
    output logic                         apple_hit
);
    localparam int N_CELLS = SIZE_X * SIZE_Y;
    localparam int FIELD_W = 2 * N_CELLS;
    localparam int SNAKE_W = 2 * COORD_W * MAX_LEN;
    localparam int FB_W    = $clog2(FIELD_W);
    localparam int SB_W    = $clog2(SNAKE_W);
    localparam logic [15:0] MAX_LEN_L = 16'(MAX_LEN);
    localparam logic [31:0] SX = 32'(SIZE_X);
    localparam logic [31:0] SY = 32'(SIZE_Y);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_DRAW, S_APPLE, S_DONE} state_t;

`ifdef FIELD_BUILDER_WALLS_EN
    function automatic logic [FIELD_W-1:0] wall_map();
        logic [FIELD_W-1:0] m;
        m = '0;
        for (int y = 0; y < SIZE_Y; y++)
            for (int x = 0; x < SIZE_X; x++)
                if (x == 0 || x == SIZE_X-1 || y == 0 || y == SIZE_Y-1)
                    m[FB_W'(2*(y*SIZE_X+x)) +: 2] = 2'b11;
        return m;
    endfunction
    localparam logic [FIELD_W-1:0] CLEAR_MAP   = wall_map();
    localparam logic [15:0]        CLEAR_EMPTY = 16'(N_CELLS - 2*(SIZE_X+SIZE_Y) + 4);
`else
    localparam logic [FIELD_W-1:0] CLEAR_MAP   = '0;
    localparam logic [15:0]        CLEAR_EMPTY = 16'(N_CELLS);
`endif

    state_t               state_q, state_d;
    logic [FIELD_W-1:0]   field_q, field_d;
    logic [15:0]          empty_q, empty_d;
    logic [15:0]          idx_q, idx_d;
    logic [15:0]          len_q, len_d;
    logic [SNAKE_W-1:0]   snake_q, snake_d;
    logic [COORD_W-1:0]   ax_q, ax_d, ay_q, ay_d;
    logic                 av_q, av_d;
    logic                 col_q, col_d, oob_q, oob_d, ah_q, ah_d;

    // Coordinate under consideration this cycle: current segment in DRAW, apple in APPLE.
    logic [SB_W-1:0]      seg_base;
    logic [COORD_W-1:0]   cur_x, cur_y;
    logic                 in_range;
    logic [31:0]          cell_lin;
    logic [FB_W-1:0]      bit_pos;
    logic [1:0]           cell_val;

    always_comb begin
        seg_base = SB_W'(idx_q) * SB_W'(2*COORD_W);
        if (state_q == S_APPLE) begin
            cur_x = ax_q;
            cur_y = ay_q;
        end else begin
            cur_x = snake_q[seg_base +: COORD_W];
            cur_y = snake_q[seg_base + SB_W'(COORD_W) +: COORD_W];
        end
        in_range = (32'(cur_x) < SX) && (32'(cur_y) < SY);
        cell_lin = 32'(cur_y) * SX + 32'(cur_x);
        bit_pos  = FB_W'(cell_lin << 1);
        cell_val = field_q[bit_pos +: 2];
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d = state_q;
        field_d = field_q;
        empty_d = empty_q;
        idx_d   = idx_q;
        len_d   = len_q;
        snake_d = snake_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        av_d    = av_q;
        col_d   = col_q;
        oob_d   = oob_q;
        ah_d    = ah_q;
        case (state_q)
            S_IDLE: if (step) begin
                len_d   = (lengh > MAX_LEN_L) ? MAX_LEN_L : lengh;
                snake_d = snake_xy;
                ax_d    = apple_x;
                ay_d    = apple_y;
                av_d    = apple_valid;
                idx_d   = '0;
                col_d   = 1'b0;
                oob_d   = 1'b0;
                ah_d    = 1'b0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                field_d = CLEAR_MAP;
                empty_d = CLEAR_EMPTY;
                state_d = (len_q == '0) ? S_APPLE : S_DRAW;
            end
            S_DRAW: begin
                if (!in_range) begin
                    oob_d = 1'b1;
                end else if (cell_val == 2'b00) begin
                    field_d[bit_pos +: 2] = 2'b01;
                    empty_d = empty_q - 16'd1;
                end else begin
                    col_d = 1'b1;
                end
                idx_d = idx_q + 16'd1;
                if (idx_d == len_q) state_d = S_APPLE;
            end
            S_APPLE: begin
                // A wall cell (11) under the apple is silently left alone.
                if (av_q) begin
                    if (!in_range) begin
                        oob_d = 1'b1;
                    end else if (cell_val == 2'b00) begin
                        field_d[bit_pos +: 2] = 2'b10;
                        empty_d = empty_q - 16'd1;
                    end else if (cell_val == 2'b01) begin
                        ah_d = 1'b1;
                    end
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            field_q <= '0;
            empty_q <= 16'(N_CELLS);
            idx_q   <= '0;
            len_q   <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            av_q    <= 1'b0;
            col_q   <= 1'b0;
            oob_q   <= 1'b0;
            ah_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            empty_q <= empty_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            av_q    <= av_d;
            col_q   <= col_d;
            oob_q   <= oob_d;
            ah_q    <= ah_d;
        end
    end

    // NOTE: the segment snapshot is storage that is always loaded before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        snake_q <= snake_d;
    end

    assign field       = field_q;
    assign empty_cells = empty_q;
    assign busy        = (state_q == S_CLEAR) || (state_q == S_DRAW) || (state_q == S_APPLE);
    assign done        = (state_q == S_DONE);
    assign collision   = col_q;
    assign oob         = oob_q;
    assign apple_hit   = ah_q;
endmodule

// File: tb/tb_field_builder.sv
// tb_field_builder: directed and randomized builds checked every cycle against a cell-array model of the field.
module tb_field_builder;
    localparam int SX = 10;
    localparam int SY = 10;
    localparam int CW = 8;
    localparam int ML = 100;
    localparam int NC = SX * SY;
    localparam int FW = 2 * NC;
`ifdef FIELD_BUILDER_WALLS_EN
    localparam bit WALLS = 1'b1;
    localparam int BASE_EMPTY = NC - 2*(SX+SY) + 4;
`else
    localparam bit WALLS = 1'b0;
    localparam int BASE_EMPTY = NC;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                step = 1'b0;
    logic [15:0]         lengh = '0;
    logic [2*CW*ML-1:0]  snake_xy = '0;
    logic [CW-1:0]       apple_x = '0;
    logic [CW-1:0]       apple_y = '0;
    logic                apple_valid = 1'b0;
    logic [FW-1:0]       field;
    logic [15:0]         empty_cells;
    logic                busy, done, collision, oob, apple_hit;

    field_builder #(.SIZE_X(SX), .SIZE_Y(SY), .COORD_W(CW), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .step(step), .lengh(lengh), .snake_xy(snake_xy),
        .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .field(field), .empty_cells(empty_cells), .busy(busy), .done(done),
        .collision(collision), .oob(oob), .apple_hit(apple_hit)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: field as an array of cell codes, filled segment by segment from the rules.
    int exp_cells[NC];
    int exp_empty;
    int busy_cnt;
    bit exp_busy, exp_done, exp_col, exp_oob, exp_ah;

    function automatic bit is_wall(int x, int y);
        return WALLS && (x == 0 || y == 0 || x == SX-1 || y == SY-1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) exp_cells[k] = 0;
        exp_empty = NC;
        busy_cnt  = 0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_col   = 1'b0;
        exp_oob   = 1'b0;
        exp_ah    = 1'b0;
    endtask

    task automatic model_build();
        int len, x, y;
        len = (int'(lengh) > ML) ? ML : int'(lengh);
        for (int yy = 0; yy < SY; yy++)
            for (int xx = 0; xx < SX; xx++)
                exp_cells[yy*SX+xx] = is_wall(xx, yy) ? 3 : 0;
        exp_col = 1'b0;
        exp_oob = 1'b0;
        exp_ah  = 1'b0;
        for (int i = 0; i < len; i++) begin
            x = int'(snake_xy[11'(16*i) +: 8]);
            y = int'(snake_xy[11'(16*i+8) +: 8]);
            if (x >= SX || y >= SY) exp_oob = 1'b1;
            else if (exp_cells[y*SX+x] != 0) exp_col = 1'b1;
            else exp_cells[y*SX+x] = 1;
        end
        if (apple_valid) begin
            x = int'(apple_x);
            y = int'(apple_y);
            if (x >= SX || y >= SY) exp_oob = 1'b1;
            else if (exp_cells[y*SX+x] == 0) exp_cells[y*SX+x] = 2;
            else if (exp_cells[y*SX+x] == 1) exp_ah = 1'b1;
        end
        exp_empty = 0;
        for (int k = 0; k < NC; k++) if (exp_cells[k] == 0) exp_empty++;
        busy_cnt = len + 2;
    endtask

    function automatic logic [FW-1:0] exp_field_vec();
        logic [FW-1:0] v;
        v = '0;
        for (int k = 0; k < NC; k++) v[8'(2*k) +: 2] = 2'(exp_cells[k]);
        return v;
    endfunction

    // Timeline: a build is busy for L+2 cycles, then one done cycle in which step is not accepted.
    always @(posedge clk) begin
        if (rst) begin
            if (exp_done) exp_done = 1'b0;
            else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) exp_done = 1'b1;
            end else if (step) model_build();
            exp_busy = (busy_cnt > 0);
        end
    end

    always @(negedge clk) begin
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        if (!exp_busy) begin
            check("field", field, exp_field_vec());
            check("empty_cells", empty_cells, exp_empty);
            check("collision", collision, exp_col);
            check("oob", oob, exp_oob);
            check("apple_hit", apple_hit, exp_ah);
        end
    end

    task automatic set_seg(input int i, input int x, input int y);
        snake_xy[11'(16*i) +: 8]   = 8'(x);
        snake_xy[11'(16*i+8) +: 8] = 8'(y);
    endtask

    function automatic logic [1:0] get_cell(input int k);
        return field[8'(2*k) +: 2];
    endfunction

    task automatic clear_inputs();
        snake_xy    = '0;
        apple_x     = '0;
        apple_y     = '0;
        apple_valid = 1'b0;
    endtask

    // Starts one build and returns at the negedge where done is seen, with the cycle count after E0.
    task automatic run_build(input int len, output int lat);
        @(negedge clk);
        lengh = 16'(len);
        step  = 1'b1;
        @(negedge clk);
        step = 1'b0;
        lat  = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, dones, first;
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_empty", empty_cells, 100);
        check("reset_field", field, 0);
        check("reset_busy", busy, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Straight three-segment snake with apple in open space.
        clear_inputs();
        set_seg(0, 2, 2); set_seg(1, 3, 2); set_seg(2, 4, 2);
        apple_x = 7; apple_y = 7; apple_valid = 1'b1;
        run_build(3, lat);
        check("t2_latency", lat, 5);
        check("t2_cell22", get_cell(22), 2'b01);
        check("t2_cell23", get_cell(23), 2'b01);
        check("t2_cell24", get_cell(24), 2'b01);
        check("t2_cell77", get_cell(77), 2'b10);
        check("t2_empty", empty_cells, BASE_EMPTY - 4);
        check("t2_model_empty", exp_empty, BASE_EMPTY - 4);
        check("t2_flags", {collision, oob, apple_hit}, 3'b000);

        // Tail segment lands back on the head.
        clear_inputs();
        set_seg(0, 5, 5); set_seg(1, 6, 5); set_seg(2, 6, 6); set_seg(3, 5, 5);
        run_build(4, lat);
        check("t3_latency", lat, 6);
        check("t3_collision", collision, 1);
        check("t3_empty", empty_cells, BASE_EMPTY - 3);
        check("t3_model_col", exp_col, 1);

        // Out-of-range segment and apple on the body.
        clear_inputs();
        set_seg(0, 1, 1); set_seg(1, 2, 1); set_seg(2, 10, 3);
        apple_x = 2; apple_y = 1; apple_valid = 1'b1;
        run_build(3, lat);
        check("t4_oob", oob, 1);
        check("t4_apple_hit", apple_hit, 1);
        check("t4_cell12", get_cell(12), 2'b01);
        check("t4_collision", collision, 0);
        check("t4_empty", empty_cells, BASE_EMPTY - 2);

        // Empty build with step held through DONE: one acceptance only.
        clear_inputs();
        @(negedge clk);
        lengh = 16'd0;
        step  = 1'b1;
        dones = 0;
        first = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first < 0) first = n;
            end
            if (n == 3) step = 1'b0;
        end
        check("t5_done_count", dones, 1);
        check("t5_done_cycle", first, 2);
        check("t5_empty", empty_cells, BASE_EMPTY);

        // Reset arrives after two segments of a five-segment build.
        clear_inputs();
        for (int i = 0; i < 5; i++) set_seg(i, i + 1, 3);
        @(negedge clk);
        lengh = 16'd5;
        step  = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("t6_field", field, 0);
        check("t6_empty", empty_cells, 100);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        rst = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("t6_no_done", dones, 0);

        // Randomized inputs every cycle; step pulses land in every state.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            step  = ($urandom_range(0, 3) == 0);
            lengh = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(90, 130))
                                                 : 16'($urandom_range(0, 12));
            for (int i = 0; i < ML; i++) set_seg(i, $urandom_range(0, 10), $urandom_range(0, 10));
            apple_x     = 8'($urandom_range(0, 10));
            apple_y     = 8'($urandom_range(0, 10));
            apple_valid = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        step = 1'b0;
        repeat (150) @(negedge clk);

`ifdef FIELD_BUILDER_WALLS_EN
        // Single segment on the left wall.
        clear_inputs();
        set_seg(0, 0, 4);
        run_build(1, lat);
        check("w_latency", lat, 3);
        check("w_empty", empty_cells, 64);
        check("w_collision", collision, 1);
        check("w_cell40", get_cell(40), 2'b11);
        check("w_cell0", get_cell(0), 2'b11);
        check("w_cell11", get_cell(11), 2'b00);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
